// File: rtl/serial_defs_pkg.sv
// Shared definitions for the bit-serial two's-complement unit.
//   MODE_* : per-word operation codes, sampled with the start-of-word strobe
//   negates(): true when a word must be negated (NEG, or ABS on a negative word)
package serial_defs;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_PASS = 2'b00;
  localparam logic [MODE_W-1:0] MODE_NEG  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ABS  = 2'b10;

  // Code 2'b11 is reserved and falls through to pass-through.
  function automatic logic negates(input logic [MODE_W-1:0] m, input logic sign);
    return (m == MODE_NEG) || ((m == MODE_ABS) && sign);
  endfunction
endpackage

// File: rtl/serial_negate_core.sv
// Serial two's-complement negation cell, LSB first.
// Bits up to and including the first 1 pass unchanged; every later bit inverts.
//   t_clk, r_n : clock, async active-low reset
//   start      : current b is bit 0 of a word (clears the seen-one history)
//   en         : b is a valid bit this cycle
//   neg        : negate this word (otherwise y = b)
//   b -> y     : serial in / serial out (combinational through the cell)
module serial_negate_core (
  input  logic t_clk,
  input  logic r_n,
  input  logic start,
  input  logic en,
  input  logic neg,
  input  logic b,
  output logic y
);
  logic r_seen;
  logic w_seen;

  // At bit 0 the stored history belongs to the previous word, so ignore it.
  assign w_seen = start ? 1'b0 : r_seen;
  assign y      = (neg & w_seen) ? ~b : b;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n)    r_seen <= 1'b0;
    else if (en) r_seen <= w_seen | b;
  end
endmodule

// File: rtl/serial_twos_comp_unit.sv
// Bit-serial PASS / NEG / ABS unit for WIDTH-bit words, LSB first.
// A whole word is captured before any result bit leaves, so every mode has the
// same latency (ABS cannot decide until the sign bit, which arrives last).
// Capture buffer and output shift register are separate, so results stream
// back-to-back while the next word is collected.
//   t_clk, r_n                  : clock, async active-low reset
//   mode, in_valid, in_sof, in_bit : serial input; mode sampled with in_sof
//   out_valid, out_sof, out_eow, out_bit : serial result burst of WIDTH cycles
//   ovf       : with out_eow, NEG/ABS of the most negative value
//   frame_err : one-cycle pulse on a framing violation
module serial_twos_comp_unit
  import serial_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              t_clk,
  input  logic              r_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_bit,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eow,
  output logic              out_bit,
  output logic              ovf,
  output logic              frame_err
);
  localparam int CW = $clog2(WIDTH + 1);

  // Input side
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_cap;
  logic [MODE_W-1:0] r_mode;
  logic              r_ferr;

  // Output side
  logic [WIDTH-1:0]  r_osh;
  logic [CW-1:0]     r_oidx;
  logic              r_ovalid;
  logic              r_oneg;
  logic              r_oovf;

  logic              w_last;
  logic [WIDTH-1:0]  w_word;
  logic              w_neg;
  logic              w_ovf;
  logic              w_osof;
  logic              w_oeow;
  logic              w_y;

  // Bit WIDTH-1 is being accepted: the word completes on this edge.
  assign w_last = in_valid & ~in_sof & (r_cnt == CW'(WIDTH - 1));
  assign w_word = {in_bit, r_cap[WIDTH-2:0]};
  assign w_neg  = negates(r_mode, in_bit);
  // Negating 100..0 yields itself; w_neg already implies a set sign for ABS.
  assign w_ovf  = w_neg & in_bit & (r_cap[WIDTH-2:0] == '0);

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      r_cnt  <= '0;
      r_cap  <= '0;
      r_mode <= MODE_PASS;
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= in_valid & (in_sof ? (r_cnt != '0) : (r_cnt == '0));
      if (in_valid) begin
        if (in_sof) begin
          // A new start always wins; any partial word is abandoned.
          r_cap[0] <= in_bit;
          r_mode   <= mode;
          r_cnt    <= CW'(1);
        end else if (r_cnt != '0) begin
          for (int i = 1; i < WIDTH; i++)
            if (r_cnt == CW'(i)) r_cap[i] <= in_bit;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
      end
    end
  end

  // A completing word can only land on or after the previous burst's last
  // bit, because a word takes at least WIDTH input cycles; reload has priority.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      r_osh    <= '0;
      r_oidx   <= '0;
      r_ovalid <= 1'b0;
      r_oneg   <= 1'b0;
      r_oovf   <= 1'b0;
    end else if (w_last) begin
      r_osh    <= w_word;
      r_oidx   <= '0;
      r_ovalid <= 1'b1;
      r_oneg   <= w_neg;
      r_oovf   <= w_ovf;
    end else if (r_ovalid) begin
      r_osh <= r_osh >> 1;
      if (r_oidx == CW'(WIDTH - 1)) begin
        r_ovalid <= 1'b0;
        r_oidx   <= '0;
      end else begin
        r_oidx <= r_oidx + CW'(1);
      end
    end
  end

  assign w_osof = r_ovalid & (r_oidx == '0);
  assign w_oeow = r_ovalid & (r_oidx == CW'(WIDTH - 1));

  serial_negate_core u_neg (
    .t_clk (t_clk),
    .r_n   (r_n),
    .start (w_osof),
    .en    (r_ovalid),
    .neg   (r_oneg),
    .b     (r_osh[0]),
    .y     (w_y)
  );

  assign out_valid = r_ovalid;
  assign out_sof   = w_osof;
  assign out_eow   = w_oeow;
  assign out_bit   = r_ovalid & w_y;
  assign ovf       = w_oeow & r_oovf;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_serial_twos_comp_unit.sv
module tb_serial_twos_comp_unit;
  localparam int W = 8;

  logic       t_clk = 1'b0;
  logic       r_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_bit = 1'b0;
  logic       out_valid, out_sof, out_eow, out_bit, ovf, frame_err;

  serial_twos_comp_unit #(.WIDTH(W)) dut (
    .t_clk(t_clk), .r_n(r_n), .mode(mode),
    .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .out_valid(out_valid), .out_sof(out_sof), .out_eow(out_eow),
    .out_bit(out_bit), .ovf(ovf), .frame_err(frame_err)
  );

  always #5 t_clk = ~t_clk;

  typedef struct packed { logic [7:0] w; logic ovf; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0, fails = 0;
  int ferr_cnt = 0, run = 0, max_run = 0, midx = 0;
  logic [7:0] macc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reassembles result bursts and pops the scoreboard on each eow.
  always @(negedge t_clk) begin
    if (!r_n) begin
      midx = 0;
      run  = 0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (midx == 0) chk("out_sof", out_sof, 1);
        macc[midx] = out_bit;
        if (midx == W - 1) begin
          chk("out_eow", out_eow, 1);
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_word: got %0h, expected no output", macc);
          end else begin
            mon_e = sb.pop_front();
            chk("word", macc, mon_e.w);
            chk("ovf", ovf, mon_e.ovf);
          end
          midx = 0;
        end else begin
          midx++;
        end
      end else begin
        run = 0;
        if (midx != 0) begin
          checks++; fails++;
          $display("FAIL burst_gap: out_valid low at bit %0d, expected 1", midx);
          midx = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin @(posedge t_clk); #1; end
  endtask

  // Mode is scrambled off the sof cycle so the latch is exercised.
  task automatic send(input logic [1:0] m, input logic [7:0] w, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i > 0) idle((i % 3) + 1);
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_bit   = w[i];
      mode     = (i == 0) ? m : ~m;
      @(posedge t_clk); #1;
    end
  endtask

  task automatic push(input logic [7:0] w, input logic o);
    exp_t e;
    e.w = w; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sof"},   out_sof,   0);
    chk({tag, "_eow"},   out_eow,   0);
    chk({tag, "_bit"},   out_bit,   0);
    chk({tag, "_ovf"},   ovf,       0);
    chk({tag, "_ferr"},  frame_err, 0);
  endtask

  initial begin
    int f0, t;
    repeat (2) begin @(posedge t_clk); #1; end
    chk_idle_outputs("reset");
    r_n = 1'b1;
    idle(2);

    // NEG 0x05 with first-bit latency check
    push(8'hFB, 0);
    send(2'b01, 8'h05, 8, 0);
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge t_clk);
    chk("latency_valid", out_valid, 1);
    chk("latency_sof", out_sof, 1);
    @(posedge t_clk); #1;
    idle(10);

    push(8'h0A, 0); send(2'b10, 8'hF6, 8, 0); idle(10);
    push(8'h0A, 0); send(2'b10, 8'h0A, 8, 0); idle(10);
    push(8'h5A, 0); send(2'b00, 8'h5A, 8, 0); idle(10);
    push(8'h33, 0); send(2'b11, 8'h33, 8, 0); idle(10);
    push(8'h80, 1); send(2'b01, 8'h80, 8, 0); idle(10);
    push(8'h00, 0); send(2'b01, 8'h00, 8, 0); idle(10);
    push(8'h80, 1); send(2'b10, 8'h80, 8, 0); idle(10);

    // Three words back-to-back
    max_run = 0;
    push(8'hFF, 0); push(8'h01, 0); push(8'h7E, 0);
    send(2'b01, 8'h01, 8, 0);
    send(2'b10, 8'hFF, 8, 0);
    send(2'b00, 8'h7E, 8, 0);
    idle(12);
    chk("b2b_run", max_run, 24);

    // Gaps inside a word
    max_run = 0;
    push(8'hC4, 0);
    send(2'b01, 8'h3C, 8, 1);
    idle(12);
    chk("gap_run", max_run, 8);

    // sof after 3 bits: first word lost
    f0 = ferr_cnt;
    send(2'b10, 8'hFF, 3, 0);
    push(8'h7F, 0);
    send(2'b10, 8'h81, 8, 0);
    idle(12);
    chk("ferr_sof", ferr_cnt - f0, 1);

    // Valid bit with no sof while idle
    f0 = ferr_cnt;
    in_valid = 1'b1; in_sof = 1'b0; in_bit = 1'b1;
    @(posedge t_clk); #1;
    idle(12);
    chk("ferr_nosof", ferr_cnt - f0, 1);

    // Reset mid-output
    push(8'hEE, 0);
    send(2'b01, 8'h12, 8, 0);
    in_valid = 1'b0;
    repeat (3) @(posedge t_clk);
    #2 r_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    sb.delete();
    @(posedge t_clk);
    @(negedge t_clk);
    r_n = 1'b1;
    @(posedge t_clk); #1;
    push(8'hEE, 0);
    send(2'b01, 8'h12, 8, 0);
    idle(12);

    t = 0;
    while (sb.size() != 0 && t < 100) begin idle(1); t++; end
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
